// File: rtl/compressor_guard.sv
// Two-zone compressor protection: per-zone min-on / run-on / min-off sequencing
// plus a shared stagger timer so the two compressors never start together.
module compressor_guard #(
    parameter int unsigned MIN_OFF = 180,
    parameter int unsigned MIN_ON  = 60,
    parameter int unsigned OVERRUN = 30,
    parameter int unsigned STAGGER = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [1:0] ac_req,
    input  logic [1:0] ht_req,
    input  logic [1:0] fo_req,
    input  logic [1:0] fh_req,
    output logic       ac1,
    output logic       ac2,
    output logic       ht1,
    output logic       ht2,
    output logic       f1O,
    output logic       f1H,
    output logic       f2O,
    output logic       f2H,
    output logic [1:0] lockout
);

    typedef enum logic [2:0] {LOCKOUT, IDLE, COOL, HEAT, RUNON} zone_state_t;

    localparam logic [7:0] MIN_OFF_C = 8'(MIN_OFF);
    localparam logic [7:0] MIN_ON_C  = 8'(MIN_ON);
    localparam logic [7:0] OVERRUN_C = 8'(OVERRUN);
    localparam logic [7:0] STAGGER_C = 8'(STAGGER);

    zone_state_t state_reg [2];
    zone_state_t state_next [2];
    logic [7:0]  cnt_reg [2];
    logic [7:0]  cnt_next [2];
    logic [7:0]  stagger_reg, stagger_next;
    logic [1:0]  cool_want, permit;
    logic [1:0]  ac_reg, ht_reg, fo_reg, fh_reg, lock_reg;
    logic [1:0]  ac_next, ht_next, fo_next, fh_next, lock_next;

    function automatic logic [7:0] dec_on_tick(input logic [7:0] value, input logic t);
        return (t && value != 8'd0) ? value - 8'd1 : value;
    endfunction

    // Zone 1 wins a simultaneous start; zone 2 is held off by the stagger reload.
    always_comb begin
        for (int z = 0; z < 2; z++) begin
            cool_want[z] = (state_reg[z] == IDLE) && ac_req[z];
        end
        permit[0] = (stagger_reg == 8'd0);
        permit[1] = (stagger_reg == 8'd0) && !cool_want[0];
    end

    always_comb begin
        stagger_next = dec_on_tick(stagger_reg, tick);
        ac_next   = 2'b00;
        ht_next   = 2'b00;
        fo_next   = 2'b00;
        fh_next   = 2'b00;
        lock_next = 2'b00;
        for (int z = 0; z < 2; z++) begin
            state_next[z] = state_reg[z];
            cnt_next[z]   = dec_on_tick(cnt_reg[z], tick);
            case (state_reg[z])
                LOCKOUT: if (cnt_reg[z] == 8'd0) state_next[z] = IDLE;
                IDLE: begin
                    if (cool_want[z] && permit[z]) begin
                        state_next[z] = COOL;
                        cnt_next[z]   = MIN_ON_C;
                        stagger_next  = STAGGER_C;
                    end else if (ht_req[z]) begin
                        state_next[z] = HEAT;
                        cnt_next[z]   = MIN_ON_C;
                    end
                end
                COOL: if (!ac_req[z] && cnt_reg[z] == 8'd0) begin
                    state_next[z] = RUNON;
                    cnt_next[z]   = OVERRUN_C;
                end
                HEAT: if (!ht_req[z] && cnt_reg[z] == 8'd0) begin
                    state_next[z] = RUNON;
                    cnt_next[z]   = OVERRUN_C;
                end
                RUNON: if (cnt_reg[z] == 8'd0) begin
                    state_next[z] = LOCKOUT;
                    cnt_next[z]   = MIN_OFF_C;
                end
                default: begin
                    state_next[z] = LOCKOUT;
                    cnt_next[z]   = MIN_OFF_C;
                end
            endcase
            // Outputs follow the state being entered so they land with it.
            ac_next[z]   = (state_next[z] == COOL);
            ht_next[z]   = (state_next[z] == HEAT);
            lock_next[z] = (state_next[z] == LOCKOUT);
            fo_next[z]   = fo_req[z] || (state_next[z] == COOL) ||
                           (state_next[z] == HEAT) || (state_next[z] == RUNON);
            fh_next[z]   = fh_req[z] && fo_next[z];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int z = 0; z < 2; z++) begin
                state_reg[z] <= LOCKOUT;
                cnt_reg[z]   <= MIN_OFF_C;
            end
            stagger_reg <= 8'd0;
            ac_reg      <= 2'b00;
            ht_reg      <= 2'b00;
            fo_reg      <= 2'b00;
            fh_reg      <= 2'b00;
            lock_reg    <= 2'b00;
        end else begin
            for (int z = 0; z < 2; z++) begin
                state_reg[z] <= state_next[z];
                cnt_reg[z]   <= cnt_next[z];
            end
            stagger_reg <= stagger_next;
            ac_reg      <= ac_next;
            ht_reg      <= ht_next;
            fo_reg      <= fo_next;
            fh_reg      <= fh_next;
            lock_reg    <= lock_next;
        end
    end

    assign ac1     = ac_reg[0];
    assign ac2     = ac_reg[1];
    assign ht1     = ht_reg[0];
    assign ht2     = ht_reg[1];
    assign f1O     = fo_reg[0];
    assign f2O     = fo_reg[1];
    assign f1H     = fh_reg[0];
    assign f2H     = fh_reg[1];
    assign lockout = lock_reg;

endmodule

// File: tb/tb_compressor_guard.sv
// Bench for compressor_guard: directed vector table, stagger/reset sequences,
// and a random run against a deadline-based reference model.
module tb_compressor_guard;

    localparam int MIN_OFF = 180;
    localparam int MIN_ON  = 60;
    localparam int OVERRUN = 30;
    localparam int STAGGER = 10;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] ac_req = 2'b00, ht_req = 2'b00, fo_req = 2'b00, fh_req = 2'b00;
    logic       ac1, ac2, ht1, ht2, f1O, f1H, f2O, f2H;
    logic [1:0] lockout;
    logic [9:0] outs;

    int errors = 0;
    int checks = 0;

    compressor_guard #(
        .MIN_OFF(MIN_OFF), .MIN_ON(MIN_ON), .OVERRUN(OVERRUN), .STAGGER(STAGGER)
    ) dut (
        .clock(clock), .reset_n(reset_n), .tick(tick),
        .ac_req(ac_req), .ht_req(ht_req), .fo_req(fo_req), .fh_req(fh_req),
        .ac1(ac1), .ac2(ac2), .ht1(ht1), .ht2(ht2),
        .f1O(f1O), .f1H(f1H), .f2O(f2O), .f2H(f2H),
        .lockout(lockout)
    );

    always #5 clock = ~clock;

    // {ac2,ac1, ht2,ht1, f2O,f1O, f2H,f1H, lockout[1:0]}
    assign outs = {ac2, ac1, ht2, ht1, f2O, f1O, f2H, f1H, lockout};

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Reference model: timers are absolute tick deadlines, a timer is expired
    // when the running tick count has reached its deadline.
    typedef enum {M_LOCK, M_IDLE, M_COOL, M_HEAT, M_RUNON} mphase_t;
    mphase_t mph [2];
    int      ticks = 0;
    int      dl [2];
    int      stag_dl = 0;

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            mph[z] = M_LOCK;
            dl[z]  = ticks + MIN_OFF;
        end
        stag_dl = ticks;
    endtask

    task automatic model_step(output logic [9:0] want);
        int ta;
        int new_stag;
        logic [1:0] wantc, perm, e_ac, e_ht, e_fo, e_fh, e_lk;
        ta = ticks + (tick ? 1 : 0);
        new_stag = stag_dl;
        for (int z = 0; z < 2; z++) wantc[z] = (mph[z] == M_IDLE) && ac_req[z];
        perm[0] = (ticks >= stag_dl);
        perm[1] = (ticks >= stag_dl) && !wantc[0];
        for (int z = 0; z < 2; z++) begin
            case (mph[z])
                M_LOCK: if (ticks >= dl[z]) mph[z] = M_IDLE;
                M_IDLE: begin
                    if (wantc[z] && perm[z]) begin
                        mph[z] = M_COOL; dl[z] = ta + MIN_ON; new_stag = ta + STAGGER;
                    end else if (ht_req[z]) begin
                        mph[z] = M_HEAT; dl[z] = ta + MIN_ON;
                    end
                end
                M_COOL: if (!ac_req[z] && ticks >= dl[z]) begin
                    mph[z] = M_RUNON; dl[z] = ta + OVERRUN;
                end
                M_HEAT: if (!ht_req[z] && ticks >= dl[z]) begin
                    mph[z] = M_RUNON; dl[z] = ta + OVERRUN;
                end
                default: if (ticks >= dl[z]) begin
                    mph[z] = M_LOCK; dl[z] = ta + MIN_OFF;
                end
            endcase
            e_ac[z] = (mph[z] == M_COOL);
            e_ht[z] = (mph[z] == M_HEAT);
            e_lk[z] = (mph[z] == M_LOCK);
            e_fo[z] = fo_req[z] || (mph[z] != M_LOCK && mph[z] != M_IDLE);
            e_fh[z] = fh_req[z] && e_fo[z];
        end
        stag_dl = new_stag;
        ticks = ta;
        want = {e_ac, e_ht, e_fo, e_fh, e_lk};
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick = 1'b0;
        ac_req = 2'b00; ht_req = 2'b00; fo_req = 2'b00; fh_req = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", int'(outs), 0);
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        int         n;
        logic [1:0] ac, ht, fo, fh;
        logic [9:0] want;
    } vec_t;

    vec_t tbl [22];

    initial begin
        int         nt, rise_at;
        logic       rise1, done;
        logic [9:0] exp_outs;
        logic [31:0] r;

        // n cycles with tick high every cycle, then compare outputs
        tbl[0]  = '{180, 2'b01, 2'b00, 2'b00, 2'b00, 10'b00_00_00_00_11};
        tbl[1]  = '{1,   2'b01, 2'b00, 2'b00, 2'b00, 10'b00_00_00_00_00};
        tbl[2]  = '{1,   2'b01, 2'b00, 2'b00, 2'b00, 10'b01_00_01_00_00};
        tbl[3]  = '{5,   2'b01, 2'b00, 2'b00, 2'b00, 10'b01_00_01_00_00};
        tbl[4]  = '{55,  2'b00, 2'b00, 2'b00, 2'b00, 10'b01_00_01_00_00};
        tbl[5]  = '{1,   2'b00, 2'b00, 2'b00, 2'b00, 10'b00_00_01_00_00};
        tbl[6]  = '{30,  2'b00, 2'b00, 2'b00, 2'b00, 10'b00_00_01_00_00};
        tbl[7]  = '{1,   2'b00, 2'b00, 2'b00, 2'b00, 10'b00_00_00_00_01};
        tbl[8]  = '{180, 2'b00, 2'b00, 2'b00, 2'b00, 10'b00_00_00_00_01};
        tbl[9]  = '{1,   2'b00, 2'b00, 2'b00, 2'b00, 10'b00_00_00_00_00};
        tbl[10] = '{1,   2'b01, 2'b01, 2'b00, 2'b00, 10'b01_00_01_00_00};
        tbl[11] = '{60,  2'b00, 2'b01, 2'b00, 2'b00, 10'b01_00_01_00_00};
        tbl[12] = '{1,   2'b00, 2'b01, 2'b00, 2'b00, 10'b00_00_01_00_00};
        tbl[13] = '{30,  2'b00, 2'b01, 2'b00, 2'b00, 10'b00_00_01_00_00};
        tbl[14] = '{1,   2'b00, 2'b01, 2'b00, 2'b00, 10'b00_00_00_00_01};
        tbl[15] = '{180, 2'b00, 2'b01, 2'b00, 2'b00, 10'b00_00_00_00_01};
        tbl[16] = '{1,   2'b00, 2'b01, 2'b00, 2'b00, 10'b00_00_00_00_00};
        tbl[17] = '{1,   2'b00, 2'b01, 2'b00, 2'b00, 10'b00_01_01_00_00};
        tbl[18] = '{5,   2'b01, 2'b01, 2'b00, 2'b00, 10'b00_01_01_00_00};
        tbl[19] = '{1,   2'b01, 2'b01, 2'b00, 2'b10, 10'b00_01_01_00_00};
        tbl[20] = '{1,   2'b01, 2'b01, 2'b10, 2'b10, 10'b00_01_11_10_00};
        tbl[21] = '{1,   2'b01, 2'b01, 2'b10, 2'b11, 10'b00_01_11_11_00};

        do_reset();
        for (int i = 0; i < 22; i++) begin
            ac_req = tbl[i].ac; ht_req = tbl[i].ht; fo_req = tbl[i].fo; fh_req = tbl[i].fh;
            tick = 1'b1;
            repeat (tbl[i].n) @(posedge clock);
            #1;
            $display("vector %0d: %0d cycles, outs=%b", i, tbl[i].n, outs);
            check($sformatf("vector_%0d", i), int'(outs), int'(tbl[i].want));
        end

        // Both zones leave lockout together; count ticks between ac1 and ac2 starts.
        do_reset();
        ac_req = 2'b11;
        rise1 = 1'b0; done = 1'b0; nt = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            tick = (cyc % 4 == 3);
            @(posedge clock);
            #1;
            if (rise1 && tick) nt++;
            if (!rise1 && ac1) begin
                rise1 = 1'b1;
                check("stagger_ac2_low_at_ac1_start", int'(ac2), 0);
            end
            if (rise1 && ac2) done = 1'b1;
        end
        $display("stagger: ac2 started %0d ticks after ac1", nt);
        check("stagger_tick_gap", done ? nt : -1, STAGGER);

        // Reset pulse in the middle of a cycle while cooling.
        check("precondition_ac1_cooling", int'(ac1), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", int'(outs), 0);
        ac_req = 2'b01; ht_req = 2'b00; tick = 1'b1;
        #3;
        reset_n = 1'b1;
        rise_at = -1;
        for (int e = 1; e <= 400 && rise_at < 0; e++) begin
            @(posedge clock);
            #1;
            if (e == MIN_OFF) check("relock_lockout_ac1", int'({lockout[0], ac1}), 2);
            if (ac1) rise_at = e;
        end
        $display("after reset pulse: ac1 rose at edge %0d", rise_at);
        check("relock_ac1_rise_edge", rise_at, MIN_OFF + 2);

        // Random stimulus against the reference model.
        do_reset();
        for (int c = 0; c < 12000; c++) begin
            r = $urandom;
            tick = (r[25:24] != 2'b00);
            if (r[3:0] == 4'd0)   ac_req ^= r[5:4];
            if (r[9:6] == 4'd0)   ht_req ^= r[11:10];
            if (r[15:12] == 4'd0) fo_req ^= r[17:16];
            if (r[21:18] == 4'd0) fh_req ^= r[23:22];
            model_step(exp_outs);
            @(posedge clock);
            #1;
            check($sformatf("random_cycle_%0d", c), int'(outs), int'(exp_outs));
        end
        $display("random run: 12000 cycles compared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/compressor_guard.md
COMPRESSOR_GUARD -- requirements
Module: compressor_guard

Interface
REQ-001 Parameter MIN_OFF, default 180, compressor minimum off time in ticks (1..255).
REQ-002 Parameter MIN_ON, default 60, compressor minimum on time in ticks (1..255).
REQ-003 Parameter OVERRUN, default 30, fan run-on after cool/heat ends, in ticks (1..255).
REQ-004 Parameter STAGGER, default 10, minimum ticks between compressor starts of zone 1 and zone 2 (1..255).
REQ-005 clock  in  1  single system clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 tick  in  1  one-cycle timing strobe (nominally 1 Hz); all timers count only on tick.
REQ-008 ac_req  in  2  cool request per zone, bit0 = zone 1, from master control ac1/ac2.
REQ-009 ht_req  in  2  heat request per zone, from ht1/ht2.
REQ-010 fo_req  in  2  fan-on request per zone, from f1O/f2O.
REQ-011 fh_req  in  2  fan-high request per zone, from f1H/f2H.
REQ-012 ac1, ac2, ht1, ht2  out  1 each  guarded relay drives.
REQ-013 f1O, f1H, f2O, f2H  out  1 each  guarded fan relay drives.
REQ-014 lockout  out  2  per zone, high while min-off timer is running.

Function
REQ-015 Each zone SHALL run an independent FSM: LOCKOUT, IDLE, COOL, HEAT, RUNON; each zone SHALL own an 8-bit down-counter.
REQ-016 LOCKOUT: counter decrements on tick; at counter 0 -> IDLE; lockout bit = 1; ac/ht = 0.
REQ-017 IDLE: ac_req = 1 and start permitted -> COOL, counter := MIN_ON; else ht_req = 1 -> HEAT, counter := MIN_ON; ac_req has priority over ht_req when both high.
REQ-018 COOL: ac = 1; counter decrements on tick, saturating at 0; ac_req = 0 and counter = 0 -> RUNON, counter := OVERRUN; ac_req deasserted before counter = 0 SHALL hold COOL until counter = 0.
REQ-019 HEAT: ht = 1; same min-on and exit rules as COOL using ht_req; ac_req rising during HEAT SHALL be ignored until HEAT exits.
REQ-020 RUNON: ac = ht = 0; counter decrements on tick; at 0 -> LOCKOUT with counter := MIN_OFF.
REQ-021 RUNON: a new ac_req or ht_req SHALL NOT shorten the run-on and SHALL NOT start a compressor; the request is served after LOCKOUT and IDLE.
REQ-022 HEAT SHALL exit through RUNON, then LOCKOUT, same as COOL: one min-off timer per zone, no heat/cool distinction.
REQ-023 Start permission (COOL only): a shared 8-bit stagger counter SHALL load STAGGER whenever either zone enters COOL and decrement on tick to 0; a zone MAY enter COOL only when the stagger counter = 0.
REQ-024 Both zones eligible for COOL in the same cycle: zone 1 enters COOL; zone 2 waits in IDLE for stagger expiry.
REQ-025 Fan on output fxO = fo_req OR state in {COOL, HEAT, RUNON}; fxH = fh_req AND fxO; f1H and f2H SHALL never be high while the corresponding fxO is low.
REQ-026 All outputs SHALL be registered, with one-cycle latency from the state or request change that causes them.
REQ-027 tick held high for multiple cycles SHALL decrement once per cycle it is high; no edge detection.
REQ-028 A counter at 0 SHALL never wrap; a load takes precedence over a decrement in the same cycle.

Reset
REQ-029 reset_n low SHALL immediately force all outputs to 0, both FSMs to LOCKOUT, both zone counters to MIN_OFF, and the stagger counter to 0.
REQ-030 Release of reset_n SHALL take effect on the next clock edge; reset asserted mid-COOL SHALL drop ac within the same cycle, asynchronously.

Verification
REQ-031 Reset released, ac_req = 01 constant: ac1 = 0 and lockout[0] = 1 for 180 ticks; ac1 = 1 one cycle after IDLE is entered.
REQ-032 Zone 1 in COOL, ac_req drops after 5 ticks: ac1 stays 1 until 60 ticks elapse; then f1O = 1 for 30 ticks; then lockout[0] = 1 for 180 ticks.
REQ-033 Both zones leave LOCKOUT in the same cycle with ac_req = 11: ac1 rises first; ac2 rises exactly 10 ticks later.
REQ-034 ac_req = 01 and ht_req = 01 together in IDLE: ac1 = 1, ht1 = 0; ac_req later 0 with ht_req still 1: ht1 stays 0 through RUNON and the 180-tick LOCKOUT, then rises.
REQ-035 fo_req = 0, fh_req = 01 in IDLE: f1H = 0; fo_req = 01: f1O = 1 and f1H = 1; reset_n pulsed low during COOL: all outputs 0 asynchronously, with a full MIN_OFF lockout afterwards.
